sr_pulse_driver: RTL

Synchronous driver for the active-low NAND set/reset latch: the transmit side of the latch's s/r interface. It accepts set/clear commands over a valid/ready handshake and emits one clean active-low pulse on s_n or r_n. Pulse width and a dead time are fixed by parameters. The block never asserts both lines at once and tracks the value the latch is expected to hold.

---
 rtl/sr_drv_pkg.sv | 19 +
 rtl/sr_drv_sync.sv | 31 +++
 rtl/sr_pulse_driver.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sr_drv_pkg.sv
// Shared types and constants for the active-low NAND S/R latch pulse driver.
package sr_drv_pkg;

    // Driver FSM states; reset enters PULSE so that an init clear pulse runs.
    typedef enum logic [1:0] {
        PULSE = 2'd0,
        DEAD  = 2'd1,
        IDLE  = 2'd2
    } drv_state_e;

    // Pulse direction: SET pulses s_n, CLR pulses r_n.
    localparam logic DIR_SET = 1'b1;
    localparam logic DIR_CLR = 1'b0;

    // Default timing in clock cycles.
    localparam int DEF_PULSE_W = 4;
    localparam int DEF_DEAD_W  = 2;

endpackage

// File: rtl/sr_drv_sync.sv
// Two-flop synchronizer for the latch q readback (used with SR_DRV_READBACK_EN).
module sr_drv_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values: shift the asynchronous input through two stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer stages, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/sr_pulse_driver.sv
// Transmit side of an active-low NAND S/R latch interface: accepts set/clear
// commands over valid/ready and emits one PULSE_W-cycle low pulse on s_n or
// r_n, followed by DEAD_W cycles with both lines high.
// Optional feature macro: SR_DRV_READBACK_EN adds the q_fb readback port, a
// 2-flop synchronizer and a sticky err flag (requires DEAD_W >= 3). Without
// it, err is tied low.
module sr_pulse_driver
    import sr_drv_pkg::*;
#(
    parameter int PULSE_W = DEF_PULSE_W,
    parameter int DEAD_W  = DEF_DEAD_W,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_set,
    output logic req_ready,
    output logic s_n,
    output logic r_n,
    output logic busy,
    output logic state_q,
`ifdef SR_DRV_READBACK_EN
    input  logic q_fb,
`endif
    output logic err
);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] DEAD_LOAD  = CNT_W'(DEAD_W - 1);

    drv_state_e       fsm_q, fsm_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             state_d;
    logic             init_q, init_d;
    logic             s_n_q, s_n_d;
    logic             r_n_q, r_n_d;

    assign req_ready = (fsm_q == IDLE);
    assign busy      = (fsm_q != IDLE);
    assign s_n       = s_n_q;
    assign r_n       = r_n_q;

    // Next-state, counter, expected-latch and line decode.
    // NOTE: every signal assigned here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        fsm_d   = fsm_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        init_d  = 1'b0;

        unique case (fsm_q)
            IDLE: begin
                if (req_valid) begin
                    dir_d = req_set;
                    cnt_d = PULSE_LOAD;
                    fsm_d = PULSE;
                end
            end
            PULSE: begin
                // The reset-release edge starts the init pulse like a handshake
                // edge would, so the counter holds there instead of counting.
                if (init_q) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == '0) begin
                    state_d = dir_q;
                    cnt_d   = DEAD_LOAD;
                    fsm_d   = DEAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DEAD: begin
                if (cnt_q == '0) begin
                    fsm_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: fsm_d = IDLE;
        endcase

        // Lines follow the next state so they change on the same edge as the
        // FSM; a single direction bit makes both-low impossible.
        s_n_d = !((fsm_d == PULSE) && (dir_d == DIR_SET));
        r_n_d = !((fsm_d == PULSE) && (dir_d == DIR_CLR));
    end

    // State registers; reset forces both lines high and arms the init clear pulse.
    // NOTE: sequential state is written with non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= PULSE;
            dir_q   <= DIR_CLR;
            cnt_q   <= PULSE_LOAD;
            state_q <= 1'b0;
            init_q  <= 1'b1;
            s_n_q   <= 1'b1;
            r_n_q   <= 1'b1;
        end else begin
            fsm_q   <= fsm_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            init_q  <= init_d;
            s_n_q   <= s_n_d;
            r_n_q   <= r_n_d;
        end
    end

`ifdef SR_DRV_READBACK_EN
    logic q_sync;
    logic err_q, err_d;

    sr_drv_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (q_fb),
        .q   (q_sync)
    );

    // Sticky mismatch: compare the settled readback on the last dead cycle.
    always_comb begin
        err_d = err_q;
        if ((fsm_q == DEAD) && (cnt_q == '0) && (q_sync != state_q)) begin
            err_d = 1'b1;
        end
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
